seq_alu: RTL and testbench

//  Parametrised, handshaked successor to the single-cycle datapath ALU.

---
 rtl/seq_alu.sv | 195 +++++++++++++++++++
 tb/tb_seq_alu.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/seq_alu.sv
// seq_alu: registered, handshaked ALU with shifts, an iterative shift-add
// multiplier and NZCV flags. Sits between operand fetch and writeback.
//
// Ports:
//   Clk, Reset          rising-edge clock, asynchronous active-high reset
//   InValid / InReady   operand handshake (accept on InValid && InReady)
//   BusA, BusB, ALUCtrl operands and opcode, sampled only on the accept edge
//   OutValid / OutReady result handshake (release on OutValid && OutReady)
//   BusW                registered result
//   Zero, Negative      registered with BusW
//   Carry, Overflow     carry-out / no-borrow and signed overflow (ADD/SUB only)
//
// Single-cycle ops have latency 1; MUL takes N shift-add steps (latency N+1).
module seq_alu #(
    parameter int unsigned N   = 64,
    parameter int unsigned SHW = $clog2(N)
) (
    input  logic         Clk,
    input  logic         Reset,
    input  logic         InValid,
    output logic         InReady,
    input  logic [N-1:0] BusA,
    input  logic [N-1:0] BusB,
    input  logic [3:0]   ALUCtrl,
    output logic         OutValid,
    input  logic         OutReady,
    output logic [N-1:0] BusW,
    output logic         Zero,
    output logic         Negative,
    output logic         Carry,
    output logic         Overflow
);

    localparam logic [3:0] OpAnd   = 4'b0000;
    localparam logic [3:0] OpOr    = 4'b0001;
    localparam logic [3:0] OpAdd   = 4'b0010;
    localparam logic [3:0] OpLsl   = 4'b0011;
    localparam logic [3:0] OpLsr   = 4'b0100;
    localparam logic [3:0] OpSub   = 4'b0110;
    localparam logic [3:0] OpPassB = 4'b0111;
    localparam logic [3:0] OpMul   = 4'b1000;

    localparam logic [SHW-1:0] CntLast = SHW'(N - 1);

    typedef enum logic [0:0] {StIdle, StMult} state_e;

    state_e         state_q, state_d;
    logic           out_valid_q, out_valid_d;
    logic [N-1:0]   busw_q, busw_d;
    logic           zero_q, zero_d;
    logic           neg_q, neg_d;
    logic           carry_q, carry_d;
    logic           ovf_q, ovf_d;
    logic [N-1:0]   a_q, a_d;
    logic [N-1:0]   b_q, b_d;
    logic [N-1:0]   acc_q, acc_d;
    logic [SHW-1:0] cnt_q, cnt_d;

    logic           accept;
    logic           release_out;
    logic [N:0]     sum;
    logic [N-1:0]   alu_w;
    logic           alu_c;
    logic           alu_v;
    logic [N-1:0]   mul_term;
    logic [N-1:0]   acc_step;

    // Gated by Reset so nothing is offered while the block is held in reset.
    assign InReady     = (state_q == StIdle) && (!out_valid_q || OutReady) && !Reset;
    assign accept      = InValid && InReady;
    assign release_out = out_valid_q && OutReady;

    // Single-cycle datapath
    always_comb begin
        sum   = '0;
        alu_w = '0;
        alu_c = 1'b0;
        alu_v = 1'b0;
        case (ALUCtrl)
            OpAnd:   alu_w = BusA & BusB;
            OpOr:    alu_w = BusA | BusB;
            OpAdd: begin
                sum   = {1'b0, BusA} + {1'b0, BusB};
                alu_w = sum[N-1:0];
                alu_c = sum[N];
                alu_v = (BusA[N-1] == BusB[N-1]) && (sum[N-1] != BusA[N-1]);
            end
            OpSub: begin
                // Carry out of A + ~B + 1 is the inverted borrow.
                sum   = {1'b0, BusA} + {1'b0, ~BusB} + {{N{1'b0}}, 1'b1};
                alu_w = sum[N-1:0];
                alu_c = sum[N];
                alu_v = (BusA[N-1] != BusB[N-1]) && (sum[N-1] != BusA[N-1]);
            end
            OpLsl:   alu_w = BusA << BusB[SHW-1:0];
            OpLsr:   alu_w = BusA >> BusB[SHW-1:0];
            OpPassB: alu_w = BusB;
            default: alu_w = '0;
        endcase
    end

    // One shift-add step of the multiplier
    assign mul_term = b_q[cnt_q] ? (a_q << cnt_q) : '0;
    assign acc_step = acc_q + mul_term;

    always_comb begin
        state_d     = state_q;
        out_valid_d = out_valid_q;
        busw_d      = busw_q;
        zero_d      = zero_q;
        neg_d       = neg_q;
        carry_d     = carry_q;
        ovf_d       = ovf_q;
        a_d         = a_q;
        b_d         = b_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;

        if (release_out) begin
            out_valid_d = 1'b0;
        end

        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    if (ALUCtrl == OpMul) begin
                        a_d     = BusA;
                        b_d     = BusB;
                        acc_d   = '0;
                        cnt_d   = '0;
                        state_d = StMult;
                    end else begin
                        busw_d      = alu_w;
                        zero_d      = (alu_w == '0);
                        neg_d       = alu_w[N-1];
                        carry_d     = alu_c;
                        ovf_d       = alu_v;
                        out_valid_d = 1'b1;
                    end
                end
            end
            StMult: begin
                acc_d = acc_step;
                cnt_d = cnt_q + 1'b1;
                // Last step writes the result directly so latency is N+1.
                if (cnt_q == CntLast) begin
                    state_d     = StIdle;
                    busw_d      = acc_step;
                    zero_d      = (acc_step == '0);
                    neg_d       = acc_step[N-1];
                    carry_d     = 1'b0;
                    ovf_d       = 1'b0;
                    out_valid_d = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q     <= StIdle;
            out_valid_q <= 1'b0;
            busw_q      <= '0;
            zero_q      <= 1'b0;
            neg_q       <= 1'b0;
            carry_q     <= 1'b0;
            ovf_q       <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            busw_q      <= busw_d;
            zero_q      <= zero_d;
            neg_q       <= neg_d;
            carry_q     <= carry_d;
            ovf_q       <= ovf_d;
            a_q         <= a_d;
            b_q         <= b_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
        end
    end

    assign OutValid = out_valid_q;
    assign BusW     = busw_q;
    assign Zero     = zero_q;
    assign Negative = neg_q;
    assign Carry    = carry_q;
    assign Overflow = ovf_q;

endmodule

// File: tb/tb_seq_alu.sv
// tb_seq_alu: directed vector table for single-cycle ops plus hand-written
// sequences for MUL latency, output stall/back-to-back issue and reset mid-MUL.
module tb_seq_alu;

    logic        Clk;
    logic        Reset;
    logic        InValid;
    logic        InReady;
    logic [63:0] BusA;
    logic [63:0] BusB;
    logic [3:0]  ALUCtrl;
    logic        OutValid;
    logic        OutReady;
    logic [63:0] BusW;
    logic        Zero;
    logic        Negative;
    logic        Carry;
    logic        Overflow;

    int unsigned total;
    int unsigned passed;

    seq_alu #(.N(64)) dut (
        .Clk      (Clk),
        .Reset    (Reset),
        .InValid  (InValid),
        .InReady  (InReady),
        .BusA     (BusA),
        .BusB     (BusB),
        .ALUCtrl  (ALUCtrl),
        .OutValid (OutValid),
        .OutReady (OutReady),
        .BusW     (BusW),
        .Zero     (Zero),
        .Negative (Negative),
        .Carry    (Carry),
        .Overflow (Overflow)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct {
        logic [3:0]  ctrl;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] w;
        logic [3:0]  zncv;
    } vec_t;

    vec_t vecs[14];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end else begin
            passed++;
        end
    endtask

    function automatic logic [3:0] flags();
        return {Zero, Negative, Carry, Overflow};
    endfunction

    initial begin
        int unsigned lat;
        logic        seen;

        total  = 0;
        passed = 0;

        // {ctrl, A, B, expected W, expected {Z,N,C,V}}
        vecs[0]  = '{4'b0010, 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 64'h8000_0000_0000_0000, 4'b0101};
        vecs[1]  = '{4'b0110, 64'h5, 64'h5, 64'h0, 4'b1010};
        vecs[2]  = '{4'b0011, 64'h1, 64'h41, 64'h2, 4'b0000};
        vecs[3]  = '{4'b0100, 64'hFFFF_FFFF_FFFF_FFFF, 64'd63, 64'h1, 4'b0000};
        vecs[4]  = '{4'b1111, 64'h5, 64'h7, 64'h0, 4'b1000};
        vecs[5]  = '{4'b0000, 64'hFF00_FF00_FF00_FF00, 64'h0F0F_0F0F_0F0F_0F0F,
                     64'h0F00_0F00_0F00_0F00, 4'b0000};
        vecs[6]  = '{4'b0001, 64'h8000_0000_0000_0000, 64'h1, 64'h8000_0000_0000_0001, 4'b0100};
        vecs[7]  = '{4'b0010, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 64'h0, 4'b1010};
        vecs[8]  = '{4'b0010, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 64'h0, 4'b1011};
        vecs[9]  = '{4'b0111, 64'd123, 64'hDEAD, 64'hDEAD, 4'b0000};
        vecs[10] = '{4'b0110, 64'h8000_0000_0000_0000, 64'h1, 64'h7FFF_FFFF_FFFF_FFFF, 4'b0011};
        vecs[11] = '{4'b0101, 64'h3, 64'h4, 64'h0, 4'b1000};
        vecs[12] = '{4'b0011, 64'h1, 64'hFFFF_FFFF_FFFF_FF04, 64'h10, 4'b0000};
        vecs[13] = '{4'b0110, 64'h0, 64'h1, 64'hFFFF_FFFF_FFFF_FFFF, 4'b0100};

        Reset    = 1'b1;
        InValid  = 1'b0;
        OutReady = 1'b1;
        BusA     = '0;
        BusB     = '0;
        ALUCtrl  = '0;

        #3;
        check("reset_inready", InReady, 0);
        check("reset_outvalid", OutValid, 0);
        check("reset_busw", BusW, 0);
        check("reset_flags", flags(), 0);
        @(posedge Clk);
        #1 Reset = 1'b0;
        @(posedge Clk);
        #1;
        check("idle_inready", InReady, 1);

        // Back-to-back single-cycle ops; each accept also drains the previous result.
        for (int i = 0; i < 14; i++) begin
            check($sformatf("vec%0d_inready", i), InReady, 1);
            ALUCtrl = vecs[i].ctrl;
            BusA    = vecs[i].a;
            BusB    = vecs[i].b;
            InValid = 1'b1;
            @(posedge Clk);
            #1;
            InValid = 1'b0;
            check($sformatf("vec%0d_outvalid", i), OutValid, 1);
            check($sformatf("vec%0d_busw", i), BusW, vecs[i].w);
            check($sformatf("vec%0d_flags", i), flags(), {60'h0, vecs[i].zncv});
        end

        // Reset in the middle of a multiply: result is discarded.
        ALUCtrl = 4'b1000;
        BusA    = 64'h3;
        BusB    = 64'h5;
        InValid = 1'b1;
        @(posedge Clk);
        #1 InValid = 1'b0;
        repeat (4) @(posedge Clk);
        #1 Reset = 1'b1;
        #1;
        check("rstmul_inready_in_reset", InReady, 0);
        check("rstmul_busw_async", BusW, 0);
        check("rstmul_flags_async", flags(), 0);
        @(posedge Clk);
        #1 Reset = 1'b0;
        @(posedge Clk);
        #1;
        check("rstmul_outvalid", OutValid, 0);
        check("rstmul_busw", BusW, 0);
        check("rstmul_inready", InReady, 1);
        seen = 1'b0;
        repeat (70) begin
            @(posedge Clk);
            #1;
            if (OutValid) seen = 1'b1;
        end
        check("rstmul_no_result", seen, 0);

        // Multiply latency and result; inputs change after accept.
        ALUCtrl = 4'b1000;
        BusA    = 64'h1_0000_0003;
        BusB    = 64'h7;
        InValid = 1'b1;
        check("mul_inready_pre", InReady, 1);
        @(posedge Clk);
        #1;
        InValid = 1'b0;
        BusA    = 64'hFFFF_0000_FFFF_0000;
        BusB    = 64'hFFFF;
        ALUCtrl = 4'b0010;
        lat     = 1;
        seen    = 1'b0;
        while (!OutValid && lat < 100) begin
            if (InReady) seen = 1'b1;
            @(posedge Clk);
            #1;
            lat++;
        end
        check("mul_latency", 64'(lat), 64'd65);
        check("mul_inready_busy", seen, 0);
        check("mul_busw", BusW, 64'h7_0000_0015);
        check("mul_flags", flags(), 0);

        // Output stall: AND result held, OR waits, then drain and accept together.
        ALUCtrl = 4'b0000;
        BusA    = 64'hFF;
        BusB    = 64'h0F;
        InValid = 1'b1;
        @(posedge Clk);
        #1;
        OutReady = 1'b0;
        ALUCtrl  = 4'b0001;
        BusA     = 64'hF0;
        BusB     = 64'h0F;
        check("hold_outvalid0", OutValid, 1);
        check("hold_busw0", BusW, 64'h0F);
        for (int c = 0; c < 10; c++) begin
            @(posedge Clk);
            #1;
            check($sformatf("hold%0d_busw", c), BusW, 64'h0F);
            check($sformatf("hold%0d_inready", c), InReady, 0);
            check($sformatf("hold%0d_outvalid", c), OutValid, 1);
        end
        check("hold_flags", flags(), 0);
        OutReady = 1'b1;
        #1;
        check("b2b_inready", InReady, 1);
        @(posedge Clk);
        #1;
        InValid = 1'b0;
        check("b2b_outvalid", OutValid, 1);
        check("b2b_busw", BusW, 64'hFF);
        @(posedge Clk);
        #1;
        check("release_outvalid", OutValid, 0);
        check("release_busw_kept", BusW, 64'hFF);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
